// File: rtl/array_behavioral_simple_pkg.sv
// Shared constants/helpers for the behavioural register array.
package array_behavioral_simple_pkg;

  // Address width needed to index n words (minimum 1 bit).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/array_behavioral_simple_if.sv
// Write/read port bundle for the behavioural register array.
interface array_behavioral_simple_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
);
  logic [WIDTH-1:0] write_data;
  logic [ADDR-1:0]  write_addr;
  logic             write_en;
  logic [ADDR-1:0]  read_addr;
  logic [WIDTH-1:0] read_data;

  modport master (
    output write_data, write_addr, write_en, read_addr,
    input  read_data
  );

  modport slave (
    input  write_data, write_addr, write_en, read_addr,
    output read_data
  );
endinterface

// File: rtl/array_behavioral_simple.sv
// Flop-based register array: one synchronous write port, one registered
// read-first read port, async active-high reset clearing all state.
module array_behavioral_simple
  import array_behavioral_simple_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR  = clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  array_behavioral_simple_if.slave  bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             wr_ok, rd_ok;

  // Range checks only exist when the address space has unused codes.
  generate
    if (DEPTH < (1 << ADDR)) begin : g_range
      localparam logic [ADDR:0] DEPTH_W = DEPTH[ADDR:0];
      assign wr_ok = {1'b0, bus.write_addr} < DEPTH_W;
      assign rd_ok = {1'b0, bus.read_addr}  < DEPTH_W;
    end else begin : g_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end
  endgenerate

  // Out-of-range reads return zero rather than an X from a missing word.
  always_comb begin
    rd_d = '0;
    if (rd_ok) rd_d = mem_q[bus.read_addr];
  end

  // Array write; out-of-range writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (bus.write_en && wr_ok) begin
      mem_q[bus.write_addr] <= bus.write_data;
    end
  end

  // Read register samples the pre-write contents (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign bus.read_data = rd_q;

endmodule

// File: tb/tb_array_behavioral_simple.sv
// Directed bench for array_behavioral_simple: DEPTH=4 and DEPTH=3 instances.
module tb_array_behavioral_simple;
  import array_behavioral_simple_pkg::*;

  localparam int W  = 8;
  localparam int A4 = clog2(4);
  localparam int A3 = clog2(3);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  array_behavioral_simple_if #(.WIDTH(W), .ADDR(A4)) b4 ();
  array_behavioral_simple_if #(.WIDTH(W), .ADDR(A3)) b3 ();

  array_behavioral_simple #(.WIDTH(W), .DEPTH(4), .ADDR(A4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );
  array_behavioral_simple #(.WIDTH(W), .DEPTH(3), .ADDR(A3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    b4.write_en = 1'b0; b4.write_addr = '0; b4.write_data = '0; b4.read_addr = '0;
    b3.write_en = 1'b0; b3.write_addr = '0; b3.write_data = '0; b3.read_addr = '0;

    // Reset state
    repeat (2) tick();
    chk("reset4", b4.read_data, 8'h00);
    chk("reset3", b3.read_data, 8'h00);
    rst = 1'b0;

    // Write 00,11,22,33 to addresses 0..3
    for (int i = 0; i < 4; i++) begin
      b4.write_en = 1'b1; b4.write_addr = 2'(i); b4.write_data = 8'(i * 8'h11);
      tick();
    end
    b4.write_en = 1'b0;

    // Readback, one address per edge
    for (int i = 0; i < 4; i++) begin
      b4.read_addr = 2'(i);
      tick();
      chk($sformatf("readback[%0d]", i), b4.read_data, 8'(i * 8'h11));
    end

    // Write-enable gating
    b4.write_en = 1'b0; b4.write_addr = 2'd2; b4.write_data = 8'hFF;
    tick();
    b4.read_addr = 2'd2;
    tick();
    chk("we_gate", b4.read_data, 8'h22);

    // Read-during-write, same address: old value first, new value next edge
    b4.write_en = 1'b1; b4.write_addr = 2'd1; b4.write_data = 8'hA5; b4.read_addr = 2'd1;
    tick();
    chk("rdw_old", b4.read_data, 8'h11);
    b4.write_en = 1'b0;
    tick();
    chk("rdw_new", b4.read_data, 8'hA5);

    // Neighbour words untouched by the write to address 1
    b4.read_addr = 2'd3;
    tick();
    chk("neighbour3", b4.read_data, 8'h33);

    // Async reset pulse between edges
    #2 rst = 1'b1;
    #1;
    chk("async_rst", b4.read_data, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b4.read_addr = 2'(i);
      tick();
      chk($sformatf("post_rst[%0d]", i), b4.read_data, 8'h00);
    end

    // Writes ignored while reset held
    rst = 1'b1;
    b4.write_en = 1'b1; b4.write_addr = 2'd0; b4.write_data = 8'h5A;
    tick();
    chk("rst_hold_rd", b4.read_data, 8'h00);
    rst = 1'b0;
    b4.write_en = 1'b0; b4.read_addr = 2'd0;
    tick();
    chk("rst_hold_wr", b4.read_data, 8'h00);

    // First edge after release is live
    b4.write_en = 1'b1; b4.write_addr = 2'd2; b4.write_data = 8'h3C;
    tick();
    b4.write_en = 1'b0; b4.read_addr = 2'd2;
    tick();
    chk("post_release_wr", b4.read_data, 8'h3C);

    // DEPTH=3: addresses 0..2 valid, address 3 out of range
    for (int i = 0; i < 3; i++) begin
      b3.write_en = 1'b1; b3.write_addr = 2'(i); b3.write_data = 8'(8'h10 * (i + 1));
      tick();
    end
    b3.write_en = 1'b1; b3.write_addr = 2'd3; b3.write_data = 8'hEE;
    tick();
    b3.write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b3.read_addr = 2'(i);
      tick();
      chk($sformatf("d3_read[%0d]", i), b3.read_data, 8'(8'h10 * (i + 1)));
    end
    b3.read_addr = 2'd3;
    tick();
    chk("d3_oor_read", b3.read_data, 8'h00);
    b3.read_addr = 2'd2;
    tick();
    chk("d3_after_oor", b3.read_data, 8'h30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
